// File: rtl/waves_nios_leds_pio_if.sv
// waves_nios_leds_pio_if: Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata)
interface waves_nios_leds_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/waves_nios_leds_pio.sv
// waves_nios_leds_pio: Avalon-MM LED output PIO with atomic set/clear and per-bit hardware blink
module waves_nios_leds_pio #(
  parameter int DATA_WIDTH = 8,
  parameter int PERIOD_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  waves_nios_leds_pio_if.slave  bus,
  output logic [DATA_WIDTH-1:0] out_port
);
  localparam logic [PERIOD_WIDTH-1:0] ONE = 1;
  logic [DATA_WIDTH-1:0]   data_q, data_d, mask_q, mask_d, out_q, out_d, wd;
  logic [PERIOD_WIDTH-1:0] half_q, half_d, cnt_q, cnt_d;
  logic                    phase_q, phase_d, wr, half_wr, term;
  logic [31:0]             rdata_q, rdata_d;
  always_comb begin
    wr      = bus.chipselect & ~bus.write_n;
    wd      = bus.writedata[DATA_WIDTH-1:0];
    half_wr = wr && bus.address == 3'd2;
    term    = cnt_q == half_q - ONE;
    data_d  = wr && bus.address == 3'd0 ? wd :
              wr && bus.address == 3'd4 ? data_q | wd :
              wr && bus.address == 3'd5 ? data_q & ~wd : data_q;
    mask_d  = wr && bus.address == 3'd1 ? wd : mask_q;
    half_d  = half_wr ? bus.writedata[PERIOD_WIDTH-1:0] : half_q;
    // a period write restarts the engine and wins over a terminal-count toggle
    cnt_d   = half_wr || half_q == '0 || term ? '0 : cnt_q + ONE;
    phase_d = half_wr || half_q == '0 ? 1'b1 : term ? ~phase_q : phase_q;
    out_d   = data_q & (~mask_q | {DATA_WIDTH{phase_q}});
    rdata_d = bus.address == 3'd0 ? 32'(data_q) :
              bus.address == 3'd1 ? 32'(mask_q) :
              bus.address == 3'd2 ? 32'(half_q) :
              bus.address == 3'd3 ? {31'b0, phase_q} : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      mask_q  <= '0;
      half_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      rdata_q <= '0;
      out_q   <= RESET_VALUE;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
    end
  end
  assign bus.readdata = rdata_q;
  assign out_port     = out_q;
endmodule
